// File: rtl/uart_tx_ctrl_pkg.sv
// Shared definitions for the UART transmit scheduler: status word layout,
// FSM state encoding and the status packing helper.
package uart_tx_ctrl_pkg;

    // Load-path address at which the status word is exposed by the top level.
    localparam logic [31:0] UART_STATUS_ADDR = 32'h0000_0104;

    // Status word bit positions.
    localparam int STAT_CNT_LSB = 0;
    localparam int STAT_CNT_W   = 5;
    localparam int STAT_FULL    = 7;
    localparam int STAT_IDLE    = 8;
    localparam int STAT_OVF     = 9;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_WAIT = 2'd2
    } tx_state_e;

    // Assemble the 32-bit status word; unused bits read as zero.
    function automatic logic [31:0] pack_status(
        input logic                  ovf,
        input logic                  idle,
        input logic                  full,
        input logic [STAT_CNT_W-1:0] cnt
    );
        logic [31:0] st;
        st = '0;
        st[STAT_CNT_LSB +: STAT_CNT_W] = cnt;
        st[STAT_FULL]                  = full;
        st[STAT_IDLE]                  = idle;
        st[STAT_OVF]                   = ovf;
        return st;
    endfunction

endpackage

// File: rtl/uart_tx_ctrl_if.sv
// CPU-side store/status bundle of the UART transmit scheduler.
// master = CPU / store path, slave = uart_tx_ctrl.
interface uart_tx_ctrl_if #(
    parameter int PTR_W = 4
) ();
    logic             cpu_we;
    logic [7:0]       cpu_data;
    logic             ovf_clr;
    logic             uart_wr_o;
    logic [7:0]       uart_dat_o;
    logic             fifo_full;
    logic [PTR_W:0]   fifo_count;
    logic             tx_idle;
    logic [31:0]      status_o;

    modport master (
        output cpu_we, cpu_data, ovf_clr,
        input  uart_wr_o, uart_dat_o, fifo_full, fifo_count, tx_idle, status_o
    );

    modport slave (
        input  cpu_we, cpu_data, ovf_clr,
        output uart_wr_o, uart_dat_o, fifo_full, fifo_count, tx_idle, status_o
    );
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with separate occupancy counter and combinational head
// read. Pushes when full and pops when empty are ignored.
module sync_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int PTR_W  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              full,
    output logic              empty,
    output logic [PTR_W:0]    count
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wptr_q, wptr_d;
    logic [PTR_W-1:0]  rptr_q, rptr_d;
    logic [PTR_W:0]    count_q, count_d;
    logic              wr_en, rd_en;

    assign full  = (count_q == (PTR_W+1)'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign rdata = mem_q[rptr_q];

    assign wr_en = push && !full;
    assign rd_en = pop && !empty;

    // Pointer and occupancy update; pointers wrap naturally at DEPTH.
    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (wr_en) wptr_d = wptr_q + 1'b1;
        if (rd_en) rptr_d = rptr_q + 1'b1;
        case ({wr_en, rd_en})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Pointer/count registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wptr_q] <= wdata;
    end

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit scheduler: buffers CPU stores in a FIFO and releases one
// byte per frame time to a UART core that has no busy indication.
module uart_tx_ctrl
    import uart_tx_ctrl_pkg::*;
#(
    parameter int DEPTH       = 16,
    parameter int PTR_W       = 4,
    parameter int BYTE_CYCLES = 8690
) (
    input  logic           sysclk,
    input  logic           cpu_resetn,
    uart_tx_ctrl_if.slave  bus
);

    localparam int                CNT_W     = $clog2(BYTE_CYCLES);
    localparam logic [CNT_W-1:0]  WAIT_LOAD = CNT_W'(BYTE_CYCLES - 2);

    tx_state_e         state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              wr_q, wr_d;
    logic [7:0]        dat_q, dat_d;
    logic              ovf_q, ovf_d;
    logic              pop;
    logic [7:0]        fifo_head;
    logic              fifo_full;
    logic              fifo_empty;
    logic [PTR_W:0]    fifo_cnt;
    logic              tx_idle;

    sync_fifo #(
        .DATA_W (8),
        .DEPTH  (DEPTH),
        .PTR_W  (PTR_W)
    ) u_fifo (
        .clk   (sysclk),
        .rst_n (cpu_resetn),
        .push  (bus.cpu_we),
        .pop   (pop),
        .wdata (bus.cpu_data),
        .rdata (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_cnt)
    );

    assign tx_idle = fifo_empty && (state_q == S_IDLE);

    assign bus.uart_wr_o  = wr_q;
    assign bus.uart_dat_o = dat_q;
    assign bus.fifo_full  = fifo_full;
    assign bus.fifo_count = fifo_cnt;
    assign bus.tx_idle    = tx_idle;
    assign bus.status_o   = pack_status(ovf_q, tx_idle, fifo_full, STAT_CNT_W'(fifo_cnt));

    // Sticky overflow: a dropped push wins over a simultaneous clear.
    always_comb begin
        ovf_d = (ovf_q && !bus.ovf_clr) || (bus.cpu_we && fifo_full);
    end

    // Pacing FSM: the head is popped on the edge that enters SEND, so the
    // registered strobe and data appear together for exactly one cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wr_d    = 1'b0;
        dat_d   = dat_q;
        pop     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!fifo_empty) begin
                    state_d = S_SEND;
                    pop     = 1'b1;
                    wr_d    = 1'b1;
                    dat_d   = fifo_head;
                end
            end
            S_SEND: begin
                state_d = S_WAIT;
                cnt_d   = WAIT_LOAD;
            end
            S_WAIT: begin
                if (cnt_q == '0) begin
                    if (!fifo_empty) begin
                        state_d = S_SEND;
                        pop     = 1'b1;
                        wr_d    = 1'b1;
                        dat_d   = fifo_head;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State, counter and output registers.
    always_ff @(posedge sysclk or negedge cpu_resetn) begin
        if (!cpu_resetn) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            wr_q    <= 1'b0;
            dat_q   <= 8'h00;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            dat_q   <= dat_d;
            ovf_q   <= ovf_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Directed self-checking bench for uart_tx_ctrl (DEPTH=4, BYTE_CYCLES=20).
module tb_uart_tx_ctrl;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc   = 0;
    int   total = 0;
    int   passed = 0;
    int   k;
    int   max_cnt;

    typedef struct {
        int         cyc;
        logic [7:0] d;
    } ev_t;
    ev_t evq[$];

    uart_tx_ctrl_if #(.PTR_W(2)) bus_if ();

    uart_tx_ctrl #(
        .DEPTH       (4),
        .PTR_W       (2),
        .BYTE_CYCLES (20)
    ) dut (
        .sysclk     (clk),
        .cpu_resetn (rst_n),
        .bus        (bus_if)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record every strobe with the index of the edge that raised it.
    always @(negedge clk) begin
        if (bus_if.uart_wr_o === 1'b1) evq.push_back('{cyc: cyc, d: bus_if.uart_dat_o});
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [31:0] ev_d(input int i);
        return (i < evq.size()) ? {24'h0, evq[i].d} : 32'hFFFF_FFFF;
    endfunction

    function automatic int ev_c(input int i);
        return (i < evq.size()) ? evq[i].cyc : -1;
    endfunction

    task automatic push(input logic [7:0] b);
        bus_if.cpu_we   = 1'b1;
        bus_if.cpu_data = b;
        tick();
        bus_if.cpu_we   = 1'b0;
    endtask

    task automatic clr_ovf();
        bus_if.ovf_clr = 1'b1;
        tick();
        bus_if.ovf_clr = 1'b0;
    endtask

    initial begin
        bus_if.cpu_we   = 1'b0;
        bus_if.cpu_data = 8'h00;
        bus_if.ovf_clr  = 1'b0;

        // Reset state
        tick(); tick();
        chk("rst_wr",     32'(bus_if.uart_wr_o),  0);
        chk("rst_dat",    32'(bus_if.uart_dat_o), 0);
        chk("rst_full",   32'(bus_if.fifo_full),  0);
        chk("rst_idle",   32'(bus_if.tx_idle),    1);
        chk("rst_count",  32'(bus_if.fifo_count), 0);
        chk("rst_status", bus_if.status_o, 32'h100);
        rst_n = 1'b1;
        evq.delete();
        repeat (100) tick();
        chk("quiet_strobes", 32'(evq.size()), 0);
        chk("quiet_status",  bus_if.status_o, 32'h100);

        // Single byte
        evq.delete();
        push(8'h41);
        k = cyc;
        chk("single_cnt",  32'(bus_if.fifo_count), 1);
        chk("single_busy", 32'(bus_if.tx_idle),    0);
        tick();
        chk("single_wr",   32'(bus_if.uart_wr_o),  1);
        chk("single_dat",  32'(bus_if.uart_dat_o), 32'h41);
        chk("single_pop",  32'(bus_if.fifo_count), 0);
        tick();
        chk("single_wr_low",  32'(bus_if.uart_wr_o),  0);
        chk("single_dat_hold", 32'(bus_if.uart_dat_o), 32'h41);
        repeat (18) tick();
        chk("single_idle_k20", 32'(bus_if.tx_idle), 0);
        tick();
        chk("single_idle_k21", 32'(bus_if.tx_idle), 1);
        chk("single_status",   bus_if.status_o, 32'h100);
        chk("single_nstrobe",  32'(evq.size()), 1);
        chk("single_edge",     32'(ev_c(0)), 32'(k + 1));

        // Three consecutive pushes
        evq.delete();
        max_cnt = 0;
        push(8'h61); k = cyc;
        if (int'(bus_if.fifo_count) > max_cnt) max_cnt = int'(bus_if.fifo_count);
        push(8'h62);
        if (int'(bus_if.fifo_count) > max_cnt) max_cnt = int'(bus_if.fifo_count);
        push(8'h63);
        if (int'(bus_if.fifo_count) > max_cnt) max_cnt = int'(bus_if.fifo_count);
        for (int i = 0; i < 70; i++) begin
            tick();
            if (int'(bus_if.fifo_count) > max_cnt) max_cnt = int'(bus_if.fifo_count);
        end
        chk("three_peak", 32'(max_cnt), 2);
        chk("three_n",    32'(evq.size()), 3);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("three_dat%0d", i), ev_d(i), 32'h61 + 32'(i));
            chk($sformatf("three_edge%0d", i), 32'(ev_c(i)), 32'(k + 1 + 20 * i));
        end
        chk("three_idle", 32'(bus_if.tx_idle), 1);

        // Six back-to-back pushes: sixth is dropped
        evq.delete();
        for (int i = 1; i <= 6; i++) push(8'(i));
        chk("six_status", bus_if.status_o, 32'h284);
        repeat (100) tick();
        chk("six_n", 32'(evq.size()), 5);
        for (int i = 0; i < 5; i++)
            chk($sformatf("six_dat%0d", i), ev_d(i), 32'(i + 1));
        chk("six_sticky", bus_if.status_o, 32'h300);
        clr_ovf();
        chk("six_clr", bus_if.status_o, 32'h100);

        // Full FIFO with a push on the same edge as a SEND pop
        evq.delete();
        for (int i = 1; i <= 5; i++) push(8'hA0 + 8'(i));
        k = cyc - 4;
        repeat (16) tick();
        chk("fullpop_pre", bus_if.status_o, 32'h084);
        push(8'hA6);
        chk("fullpop_edge", 32'(cyc), 32'(k + 21));
        chk("fullpop_cnt", 32'(bus_if.fifo_count), 3);
        chk("fullpop_ovf", 32'(bus_if.status_o[9]), 1);
        chk("fullpop_wr",  32'(bus_if.uart_wr_o), 1);
        chk("fullpop_dat", 32'(bus_if.uart_dat_o), 32'hA2);
        repeat (90) tick();
        chk("fullpop_n", 32'(evq.size()), 5);
        for (int i = 0; i < 5; i++)
            chk($sformatf("fullpop_dat%0d", i), ev_d(i), 32'hA1 + 32'(i));
        clr_ovf();

        // Asynchronous reset mid-WAIT with three bytes queued
        for (int i = 1; i <= 4; i++) push(8'hB0 + 8'(i));
        repeat (5) tick();
        chk("arst_pre_cnt", 32'(bus_if.fifo_count), 3);
        chk("arst_pre_dat", 32'(bus_if.uart_dat_o), 32'hB1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_wr",     32'(bus_if.uart_wr_o),  0);
        chk("arst_dat",    32'(bus_if.uart_dat_o), 0);
        chk("arst_cnt",    32'(bus_if.fifo_count), 0);
        chk("arst_idle",   32'(bus_if.tx_idle),    1);
        chk("arst_status", bus_if.status_o, 32'h100);
        tick(); tick();
        rst_n = 1'b1;
        evq.delete();
        repeat (60) tick();
        chk("arst_quiet",  32'(evq.size()), 0);
        chk("arst_status2", bus_if.status_o, 32'h100);
        push(8'hC5);
        tick();
        chk("arst_new_wr",  32'(bus_if.uart_wr_o),  1);
        chk("arst_new_dat", 32'(bus_if.uart_dat_o), 32'hC5);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/uart_tx_ctrl.md
Name: uart_tx_ctrl

Overview:
Transmit scheduler between the CPU store path and the UART core.
- Buffers bytes stored to UART_ADDR in a FIFO.
- Paces them to the UART core: one `uart_wr` pulse per frame time. The core has no busy output, so pacing is the only guard against overrun.
- Exports a status word, readable through the load path at UART_STATUS_ADDR, so software can poll for space or completion instead of spinning blindly.

Parameters:
- DEPTH, 16: FIFO entries. Power of two, ≥2.
- PTR_W, 4: log2(DEPTH).
- BYTE_CYCLES, 8690: sysclk cycles reserved per UART frame (10 bits × 868 clk/bit + guard). Must be ≥2.

Ports:
- sysclk  in  1  system clock; all state on rising edge.
- cpu_resetn  in  1  reset, asynchronous, active-low.
- cpu_we  in  1  store to UART_ADDR, already qualified by is_store.
- cpu_data  in  8  byte to transmit.
- ovf_clr  in  1  clears the sticky overflow flag.
- uart_wr_o  out  1  one-cycle write strobe to the UART core.
- uart_dat_o  out  8  byte presented with uart_wr_o.
- fifo_full  out  1  count == DEPTH.
- fifo_count  out  PTR_W+1  current occupancy.
- tx_idle  out  1  FIFO empty and FSM in IDLE.
- status_o  out  32  {22'b0, overflow, tx_idle, fifo_full, 1'b0, 1'b0, fifo_count zero-extended to 5 bits}. Bits [4:0] = count, bit 7 = full, bit 8 = idle, bit 9 = overflow.

Behaviour:
- Reset (cpu_resetn low, async), regardless of state or mid-frame:
  - pointers = 0, count = 0, state = IDLE, counter = 0;
  - uart_wr_o = 0, uart_dat_o = 8'h00, overflow = 0;
  - fifo_full = 0, tx_idle = 1, status_o = 32'h100.
  - Bytes already in the FIFO are discarded.
- Push: cpu_we high at an edge with count < DEPTH (sampled before that edge's pop) → write cpu_data at wptr, wptr+1 mod DEPTH.
- Push when full, even with a simultaneous pop → byte dropped, overflow ← 1.
- Overflow is sticky. ovf_clr clears it. ovf_clr and a new overflow on the same edge → overflow = 1.
- Pointers wrap modulo DEPTH. count = pushes − pops, kept in a separate PTR_W+1 register. Same-edge push and pop leave count unchanged.
- FSM (3 states), all outputs registered:
  - IDLE: count ≠ 0 at an edge → SEND.
  - SEND, held exactly 1 cycle: uart_wr_o = 1, uart_dat_o = FIFO head; the head is popped on entry. Next state WAIT; counter ← BYTE_CYCLES−2.
  - WAIT: counter decrements each cycle. At counter == 0: count ≠ 0 → SEND, else → IDLE.
- Latency: a push into an empty FIFO with the FSM in IDLE at edge k gives uart_wr_o high in cycle k+1..k+2.
- With a continuous backlog, strobes are exactly BYTE_CYCLES cycles apart.
- uart_dat_o holds the last sent byte until the next SEND.
- A push during WAIT never shortens the wait.
- Byte order is strictly FIFO. No byte is emitted twice.
- Outside SEND, uart_wr_o is 0.

Decomposition:
- define.vh gains:
  - UART_STATUS_ADDR;
  - status bit positions: STAT_CNT_LSB = 0, STAT_FULL = 7, STAT_IDLE = 8, STAT_OVF = 9;
  - FSM encodings: S_IDLE, S_SEND, S_WAIT.
- One sub-module: sync_fifo (DEPTH/PTR_W parameters, push/pop/full/empty/count, head read combinational from rptr). It is reusable by a later RX path.
- Top-level integration (address decode, load-mux entry for UART_STATUS_ADDR) stays in top and is not part of this block.

Test Plan (BYTE_CYCLES = 20, DEPTH = 4):
- Reset release, no stimulus → uart_wr_o = 0 for 100 cycles; status_o = 32'h100.
- Single push 8'h41 at edge k → uart_wr_o high only in cycle k+1; uart_dat_o = 8'h41; tx_idle returns to 1 at edge k+21.
- Push 8'h61, 8'h62, 8'h63 on consecutive edges → three strobes 20 cycles apart carrying 61, 62, 63 in order; fifo_count peaks at 2.
- Six back-to-back pushes 8'h01–8'h06 starting from idle → bytes 01–05 accepted (one already popped into SEND) and byte 06 dropped; overflow = 1 (status bit 9); output sequence 01–05 only; ovf_clr pulse → bit 9 = 0.
- Full FIFO plus a push on the same edge as a SEND pop → push still dropped; overflow set; count goes 4→3.
- cpu_resetn low mid-WAIT with 3 bytes queued → outputs return to reset values immediately without waiting for a clock; no further strobes after release until a new push.
